warp_regfile_param: RTL and testbench
=====================================

Name: warp_regfile_param

Overview:
- Parametrised next-generation per-warp, per-lane SIMT register file: NUM_WARPS banks of NUM_REGS x DATA_W registers per lane, LANES lanes, NUM_RD read ports, one lane-masked write port.
- Adds over the fixed 8-lane/2-port block: registered reads with write-to-read bypass, independent read and write warp selects, optional hardwired-zero register 0, and a per-warp hardware clear sequencer with busy/ready handshake.
- Sits between the warp scheduler/operand collector and the lane ALUs.

Parameters:
LANES, 8, number of SIMD lanes
NUM_REGS, 32, registers per lane per warp (power of 2, >=2)
DATA_W, 32, register width
NUM_WARPS, 16, warp banks (power of 2, >=1)
NUM_RD, 2, read ports
ZERO_REG0, 0, 1 = register 0 reads 0 and ignores writes
ADDR_W, $clog2(NUM_REGS), derived register address width
WARP_W, max(1,$clog2(NUM_WARPS)), derived warp index width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rd_warp  in  WARP_W  warp for all read ports
read_en  in  NUM_RD*LANES  per-port per-lane read enable, port p lanes at [p*LANES +: LANES]
raddr  in  NUM_RD*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*LANES*DATA_W  port p lane l at [(p*LANES+l)*DATA_W +: DATA_W]
wr_warp  in  WARP_W  write warp
write_en  in  LANES  per-lane write enable
waddr  in  ADDR_W  write address
wdata  in  LANES*DATA_W  lane l at [l*DATA_W +: DATA_W]
wr_ready  out  1  1 = write port accepted this cycle
clr_req  in  1  request clear of warp clr_warp
clr_warp  in  WARP_W  warp to clear, sampled when request accepted
clr_busy  out  1  clear sequence in progress

Behaviour:
- Reset: rdata=0, clr_busy=0, wr_ready=1 (comb. !clr_busy), FSM=IDLE, counter=0. Array contents not reset; undefined until written or cleared.
- Write: on posedge with wr_ready=1, lane l with write_en[l]=1 stores wdata lane l at [wr_warp][waddr][l]. Disabled lanes are untouched. Write with wr_ready=0 is dropped; the requester must hold until wr_ready=1.
- Read: 1-cycle latency. On posedge, for each port p and lane l with read_en=1, rdata(p,l) <= array[rd_warp][raddr_p][l]. Lanes with read_en=0 hold their previous rdata.
- Bypass: if the same edge commits a write (external or clear) to the same warp, address and lane being read, rdata takes the new value, not the stale one. Ports are independent; all NUM_RD ports may read the same address.
- ZERO_REG0=1: raddr=0 yields 0 on all lanes and bypasses; writes to addr 0 are ignored; clear still sweeps address 0 harmlessly.
- Clear FSM IDLE->CLEAR: taken when clr_req=1 in IDLE. Latch clr_warp; cnt=0; clr_busy=1 from the next cycle.
- CLEAR state: each cycle write 0 to all lanes of [warp][cnt]; cnt++. After cnt=NUM_REGS-1 is written, return to IDLE. Busy lasts exactly NUM_REGS cycles.
- clr_req in CLEAR is ignored; no queueing.
- External write in the accept cycle (IDLE, clr_req=1): accepted and committed first. Subsequent clear cycles overwrite it if it targets the cleared warp.
- Reads during CLEAR are allowed; addresses not yet cleared return old data.
- Reset asserted mid-clear: immediately IDLE, clr_busy=0, rdata=0. Partially cleared warp contents are left as is.
- Counter is ADDR_W bits; wrap to 0 on exit; no out-of-range addresses exist.

Test Plan:
- Per-lane mask: write warp 3 reg 5 with all lanes = 32'hA5A5_0000+l, then write_en=8'h0F with 32'hFFFF_FFFF; read port 0 -> lanes 0-3 = FFFF_FFFF, lanes 4-7 = A5A5_0004..0007, one cycle after read_en.
- Full sweep: for every warp 0-15, reg 0-31 and 10 random values, write all lanes then read on port 0, port 1 and both -> rdata matches on all lanes and both ports; rd_warp != wr_warp reads the untouched bank.
- Bypass: same-cycle write 32'h1234_5678 and read of warp 2 reg 7 lane 0 -> rdata lane 0 = 1234_5678 next cycle; a lane with read_en=0 holds its prior value.
- Clear: fill warp 9 with nonzero values, pulse clr_req -> clr_busy high exactly 32 cycles and wr_ready low for that window; after exit, all warp 9 regs read 0 and warp 8 is unchanged.
- Stall/reset: write during busy is dropped and lands only after wr_ready=1; assert rst at clear cycle 10 -> clr_busy=0 and rdata=0 asynchronously; regs 0-9 are 0 and regs 10-31 keep old data.
- ZERO_REG0=1 build: write 32'hDEAD_BEEF to reg 0 -> reads return 0 on all ports and lanes, including the bypass case.

Source files
------------

// File: rtl/warp_regfile_param.sv
// Per-warp, per-lane SIMT register file. It has NUM_RD registered read ports, one
// lane-masked write port with read bypass, and a sequencer that clears one warp bank.
module warp_regfile_param #(
  parameter int LANES     = 8,
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_WARPS = 16,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 0,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int WARP_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WARP_W-1:0]                rd_warp,
  input  logic [NUM_RD*LANES-1:0]          read_en,
  input  logic [NUM_RD*ADDR_W-1:0]         raddr,
  output logic [NUM_RD*LANES*DATA_W-1:0]   rdata,
  input  logic [WARP_W-1:0]                wr_warp,
  input  logic [LANES-1:0]                 write_en,
  input  logic [ADDR_W-1:0]                waddr,
  input  logic [LANES*DATA_W-1:0]          wdata,
  output logic                             wr_ready,
  input  logic                             clr_req,
  input  logic [WARP_W-1:0]                clr_warp,
  output logic                             clr_busy
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WARP_W-1:0]   cwarp_q, cwarp_d;

  logic [DATA_W-1:0]   mem_q [NUM_WARPS][NUM_REGS][LANES];

  logic [LANES-1:0]        we_lane;
  logic [WARP_W-1:0]       we_warp;
  logic [ADDR_W-1:0]       we_addr;
  logic [LANES*DATA_W-1:0] we_data;

  logic [ADDR_W-1:0]               ra;
  logic [NUM_RD*LANES*DATA_W-1:0]  rd_val;
  logic [NUM_RD*LANES*DATA_W-1:0]  rdata_q;

  function automatic logic zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG0 != 0) && (a == '0);
  endfunction

  // Clear sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cwarp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cwarp_q <= cwarp_d;
    end
  end

  // Clear sequencer: next state; requests arriving mid-clear are dropped, not queued
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cwarp_d = cwarp_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          cwarp_d = clr_warp;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear sequencer: outputs
  always_comb begin
    clr_busy = (state_q == S_CLEAR);
    wr_ready = !clr_busy;
  end

  // Single write source per cycle: the sweep owns the port while clearing
  always_comb begin
    we_lane = '0;
    we_warp = wr_warp;
    we_addr = waddr;
    we_data = wdata;
    if (state_q == S_CLEAR) begin
      we_lane = '1;
      we_warp = cwarp_q;
      we_addr = cnt_q;
      we_data = '0;
    end else if (!zero_reg(waddr)) begin
      we_lane = write_en;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we_lane[l]) begin
        mem_q[we_warp][we_addr][l] <= we_data[l*DATA_W +: DATA_W];
      end
    end
  end

  // Read select with bypass of the write committing on the same edge
  always_comb begin
    rd_val = '0;
    ra     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = raddr[p*ADDR_W +: ADDR_W];
      for (int l = 0; l < LANES; l++) begin
        if (zero_reg(ra)) begin
          rd_val[(p*LANES+l)*DATA_W +: DATA_W] = '0;
        end else if (we_lane[l] && (we_warp == rd_warp) && (we_addr == ra)) begin
          rd_val[(p*LANES+l)*DATA_W +: DATA_W] = we_data[l*DATA_W +: DATA_W];
        end else begin
          rd_val[(p*LANES+l)*DATA_W +: DATA_W] = mem_q[rd_warp][ra][l];
        end
      end
    end
  end

  // Read output register; disabled lanes hold their last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD*LANES; i++) begin
        if (read_en[i]) begin
          rdata_q[i*DATA_W +: DATA_W] <= rd_val[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_warp_regfile_param.sv
// Directed bench for warp_regfile_param: a reference array model feeds a scoreboard
// queue, and a second small instance covers the hardwired-zero register 0 build.
module tb_warp_regfile_param;
  localparam int LANES = 8, NUM_REGS = 32, DATA_W = 32, NUM_WARPS = 16, NUM_RD = 2;
  localparam int ADDR_W = 5, WARP_W = 4;
  localparam int RW = NUM_RD*LANES*DATA_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [WARP_W-1:0]         rd_warp, wr_warp, clr_warp;
  logic [NUM_RD*LANES-1:0]   read_en;
  logic [NUM_RD*ADDR_W-1:0]  raddr;
  logic [RW-1:0]             rdata;
  logic [LANES-1:0]          write_en;
  logic [ADDR_W-1:0]         waddr;
  logic [LANES*DATA_W-1:0]   wdata;
  logic                      wr_ready, clr_req, clr_busy;

  logic [0:0]   z_rd_warp, z_wr_warp, z_clr_warp;
  logic [3:0]   z_read_en, z_raddr;
  logic [127:0] z_rdata;
  logic [1:0]   z_write_en, z_waddr;
  logic [63:0]  z_wdata;
  logic         z_wr_ready, z_clr_req, z_clr_busy;

  warp_regfile_param #(.LANES(LANES), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W),
    .NUM_WARPS(NUM_WARPS), .NUM_RD(NUM_RD), .ZERO_REG0(0)) dut (
    .clk(clk), .rst(rst), .rd_warp(rd_warp), .read_en(read_en), .raddr(raddr),
    .rdata(rdata), .wr_warp(wr_warp), .write_en(write_en), .waddr(waddr),
    .wdata(wdata), .wr_ready(wr_ready), .clr_req(clr_req), .clr_warp(clr_warp),
    .clr_busy(clr_busy));

  warp_regfile_param #(.LANES(2), .NUM_REGS(4), .DATA_W(32), .NUM_WARPS(2),
    .NUM_RD(2), .ZERO_REG0(1)) dut_z (
    .clk(clk), .rst(rst), .rd_warp(z_rd_warp), .read_en(z_read_en), .raddr(z_raddr),
    .rdata(z_rdata), .wr_warp(z_wr_warp), .write_en(z_write_en), .waddr(z_waddr),
    .wdata(z_wdata), .wr_ready(z_wr_ready), .clr_req(z_clr_req), .clr_warp(z_clr_warp),
    .clr_busy(z_clr_busy));

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [RW-1:0] exp;
  } sb_t;

  sb_t          sbq[$];
  logic [31:0]  mm [NUM_WARPS][NUM_REGS][LANES];
  logic [RW-1:0] exp_rd;
  bit           m_busy;
  int           m_cnt, m_cwarp;
  int           n_chk = 0, n_pass = 0, n_fail = 0;
  int           busy_cnt;
  logic [255:0] cexp;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    write_en = '0;
    read_en  = '0;
    clr_req  = 1'b0;
  endtask

  task automatic set_wr(input int w, input int r, input logic [LANES-1:0] en);
    wr_warp  = WARP_W'(w);
    waddr    = ADDR_W'(r);
    write_en = en;
  endtask

  task automatic set_rd(input int w, input int r0, input int r1, input logic [15:0] en);
    rd_warp = WARP_W'(w);
    raddr   = {ADDR_W'(r1), ADDR_W'(r0)};
    read_en = en;
  endtask

  // One clock: check handshake, advance model, push expected rdata, compare after edge
  task automatic tick(input string tag);
    sb_t e;
    chk({tag, "_ready"}, RW'(wr_ready), RW'(!m_busy));
    chk({tag, "_busy"}, RW'(clr_busy), RW'(m_busy));
    if (m_busy) begin
      for (int l = 0; l < LANES; l++) mm[m_cwarp][m_cnt][l] = 32'h0;
      if (m_cnt == NUM_REGS - 1) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int l = 0; l < LANES; l++)
        if (write_en[l]) mm[wr_warp][waddr][l] = wdata[l*32 +: 32];
      if (clr_req) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_cwarp = int'(clr_warp);
      end
    end
    for (int p = 0; p < NUM_RD; p++)
      for (int l = 0; l < LANES; l++)
        if (read_en[p*LANES+l])
          exp_rd[(p*LANES+l)*32 +: 32] = mm[rd_warp][raddr[p*ADDR_W +: ADDR_W]][l];
    e.tag = tag;
    e.exp = exp_rd;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    chk(e.tag, rdata, e.exp);
  endtask

  initial begin
    rst = 1'b1;
    rd_warp = '0; wr_warp = '0; clr_warp = '0; raddr = '0; waddr = '0; wdata = '0;
    idle();
    z_rd_warp = '0; z_wr_warp = '0; z_clr_warp = '0; z_read_en = '0; z_raddr = '0;
    z_write_en = '0; z_waddr = '0; z_wdata = '0; z_clr_req = 1'b0;
    m_busy = 1'b0; m_cnt = 0; m_cwarp = 0; exp_rd = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy", RW'(clr_busy), RW'(0));
    chk("rst_ready", RW'(wr_ready), RW'(1));
    chk("z_rst_rdata", RW'(z_rdata), '0);
    rst = 1'b0;

    // Per-lane write mask
    set_wr(3, 5, '1);
    for (int l = 0; l < LANES; l++) wdata[l*32 +: 32] = 32'hA5A5_0000 + l;
    tick("mask_wr_all");
    idle(); set_wr(3, 5, 8'h0F); wdata = {LANES{32'hFFFF_FFFF}};
    tick("mask_wr_lo");
    idle(); set_rd(3, 5, 0, 16'h00FF);
    tick("mask_rd");
    for (int l = 0; l < LANES; l++) cexp[l*32 +: 32] = (l < 4) ? 32'hFFFF_FFFF : 32'hA5A5_0000 + l;
    chk("mask_lanes", RW'(rdata[255:0]), RW'(cexp));

    // Same-edge write/read bypass and hold of a disabled lane
    idle(); set_wr(2, 7, '1);
    for (int l = 0; l < LANES; l++) wdata[l*32 +: 32] = 32'h1111_0000 + l;
    tick("byp_pre_wr");
    idle(); set_rd(2, 7, 7, 16'h00FF);
    tick("byp_pre_rd");
    idle(); set_wr(2, 7, '1);
    for (int l = 0; l < LANES; l++) wdata[l*32 +: 32] = 32'h2222_0000 + l;
    wdata[31:0] = 32'h1234_5678;
    set_rd(2, 7, 7, 16'h0001);
    tick("bypass");
    chk("bypass_l0", RW'(rdata[31:0]), RW'(32'h1234_5678));
    chk("hold_l1", RW'(rdata[63:32]), RW'(32'h1111_0001));

    // Full sweep: every warp/reg, rotating read-port patterns, cross-bank reads
    for (int w = 0; w < NUM_WARPS; w++)
      for (int r = 0; r < NUM_REGS; r++)
        for (int v = 0; v < 10; v++) begin
          idle(); set_wr(w, r, '1);
          for (int l = 0; l < LANES; l++) wdata[l*32 +: 32] = $urandom() | 32'h1;
          if (w > 0) set_rd(w - 1, r, r, 16'hFF00);
          tick("sweep_wr");
          idle();
          set_rd(w, r, r, (v % 3 == 0) ? 16'h00FF : (v % 3 == 1) ? 16'hFF00 : 16'hFFFF);
          tick("sweep_rd");
        end

    // Clear of warp 9 with an accept-cycle write and a stalled write to warp 4
    idle(); clr_req = 1'b1; clr_warp = 4'd9; set_wr(9, 4, '1);
    for (int l = 0; l < LANES; l++) wdata[l*32 +: 32] = 32'hCAFE_0000 + l;
    tick("clr_accept");
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      clr_req = (c < 3); clr_warp = 4'd8;
      set_wr(4, 2, '1);
      for (int l = 0; l < LANES; l++) wdata[l*32 +: 32] = 32'h0BAD_0000 + l;
      set_rd(9, 4, c % 32, 16'hFFFF);
      if (clr_busy) busy_cnt++;
      tick("clr_run");
    end
    chk("busy_len", RW'(busy_cnt), RW'(32));
    idle(); set_rd(4, 2, 2, 16'h00FF);
    tick("stall_landed");
    for (int l = 0; l < LANES; l++) cexp[l*32 +: 32] = 32'h0BAD_0000 + l;
    chk("stall_val", RW'(rdata[255:0]), RW'(cexp));
    for (int r = 0; r < NUM_REGS; r++) begin
      idle(); set_rd(9, r, r, 16'h00FF);
      tick("clr_w9");
      chk("clr_zero", RW'(rdata[255:0]), '0);
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      idle(); set_rd(8, r, r, 16'hFF00);
      tick("keep_w8");
    end

    // Reset during a clear of warp 6 after ten sweep cycles
    idle(); clr_req = 1'b1; clr_warp = 4'd6;
    tick("clr6_accept");
    idle();
    repeat (10) tick("clr6_run");
    rst = 1'b1;
    #1;
    chk("rstmid_busy", RW'(clr_busy), RW'(0));
    chk("rstmid_ready", RW'(wr_ready), RW'(1));
    chk("rstmid_rdata", rdata, '0);
    #1;
    rst = 1'b0;
    m_busy = 1'b0; m_cnt = 0; exp_rd = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      idle(); set_rd(6, r, r, 16'h00FF);
      tick("part_w6");
      if (r < 10) chk("part_clr", RW'(rdata[255:0]), '0);
      else chk("part_keep", RW'(rdata[31:0] != 32'h0), RW'(1));
    end

    // Hardwired-zero register 0 build
    idle();
    chk("z_ready", RW'(z_wr_ready), RW'(1));
    z_wr_warp = 1'b0; z_waddr = 2'd0; z_write_en = 2'b11; z_wdata = {2{32'hDEAD_BEEF}};
    z_rd_warp = 1'b0; z_raddr = 4'b0000; z_read_en = 4'hF;
    @(negedge clk);
    chk("z_bypass0", RW'(z_rdata), '0);
    z_wr_warp = 1'b1; z_waddr = 2'd1; z_write_en = 2'b11; z_wdata = {32'h5555_0001, 32'h5555_0000};
    z_rd_warp = 1'b1; z_raddr = 4'b0101; z_read_en = 4'hF;
    @(negedge clk);
    chk("z_bypass1", RW'(z_rdata), RW'({32'h5555_0001, 32'h5555_0000, 32'h5555_0001, 32'h5555_0000}));
    z_write_en = 2'b00; z_rd_warp = 1'b0; z_raddr = 4'b0000; z_read_en = 4'hF;
    @(negedge clk);
    chk("z_reg0", RW'(z_rdata), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
